fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 4-stage pipeline. Holds the PC and drives the instruction memory's read address. The memory read is combinational, so data returns in the same cycle. Captures the returned word together with its PC in a 2-entry fetch buffer and presents it to the decode stage with a valid/ready handshake. Accepts branch/jump redirects from downstream and flushes wrong-path entries.

Parameters:
ADDR_W, 32 (=`ISIZE), PC / instruction-memory address width; memory is word-addressed
INSTR_W, 32 (=`DSIZE), instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
rst  input  1  reset (synchronous, active-high)
fetch_en  input  1  1 = fetching allowed; 0 = no new fetches, buffer drains
imem_addr  output  ADDR_W  read address to instruction memory (= pc, combinational)
imem_rdata  input  INSTR_W  instruction word returned combinationally for imem_addr
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  ADDR_W  redirect target (word address)
out_valid  output  1  head buffer entry is valid for decode
out_ready  input  1  decode accepts head entry this cycle
out_instr  output  INSTR_W  head instruction
out_pc  output  ADDR_W  PC of head instruction

Behaviour:
- Reset (rst=1 at posedge):
  - pc <= RESET_PC.
  - Buffer count <= 0; read and write pointers <= 0.
  - out_valid = 0. out_instr and out_pc are don't-care while out_valid=0 and are reset to 0.
  - Reset mid-operation discards all buffered entries. Any pending redirect is ignored.
- imem_addr = pc at all times. Instruction memory is never written by this block.
- Pop: pop = out_valid & out_ready.
- Push, when no redirect: push = fetch_en & ~redirect_valid & (count<2 | pop).
  - On push, enqueue {pc, imem_rdata} and set pc <= pc+1.
  - pc wraps modulo 2^ADDR_W.
  - A full buffer with a simultaneous pop still pushes, giving zero-bubble streaming.
- Count update: count <= count + push - pop, range 0..2.
- Output: out_valid = (count != 0). out_instr and out_pc are driven from the head entry, registered storage only, with no combinational path from imem_rdata.
- Stall: with out_valid=1 and out_ready=0, the head entry and its outputs hold stable. PC advances until the buffer is full, then holds.
- Redirect:
  - redirect_valid=1 at a posedge sets pc <= redirect_pc, count <= 0, and resets both pointers.
  - No push occurs that cycle. Redirect has priority over push and pop.
  - A head handshake completing in the redirect cycle counts as delivered; decode squashes it itself.
  - out_valid=0 in cycle N+1. First target instruction appears at out in cycle N+2.
- Latency: PC-to-out is 1 cycle. With out_ready=1 and fetch_en=1, sustained throughput is 1 instruction per cycle.
- Startup: first instruction (pc=RESET_PC) is valid in the first cycle after rst deasserts + 1.
- Simultaneous fetch_en=0 and redirect_valid=1: redirect still applies and the buffer flushes.

Optional Feature:
FETCH_STATS_EN
- Defined:
  - Adds output fetch_count[31:0], incremented on every push.
  - Adds output stall_count[31:0], incremented on every cycle with out_valid & ~out_ready.
  - Both counters clear on rst and wrap at 2^32.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds the ADDR_W/INSTR_W defaults (`ISIZE, `DSIZE), RESET_PC, and the buffer entry layout {pc, instr}.
- One sub-module, fetch_buf: a 2-entry synchronous FIFO with push, pop, flush, count, and head outputs.
- Flush is a synchronous clear with priority over push and pop.
- fetch_stage holds the PC and handshake logic.

Test Plan:
1. Reset with RESET_PC=0; imem holds instr = 0x100+addr; out_ready=1, fetch_en=1. Required: out_valid from first cycle after reset +1; out_pc = 0,1,2,3 on consecutive cycles; out_instr = 0x100,0x101,0x102,0x103.
2. Stall: out_ready=0 for 4 cycles after first valid. Required: count reaches 2; pc holds at 2; out_pc=0 stable. Release out_ready=1: out_pc = 0,1,2,3 with no bubble.
3. Redirect while full: redirect_valid=1, redirect_pc=0x10. Required: next cycle out_valid=0, pc=0x10; following cycle out_pc=0x10, out_instr=0x110; then out_pc=0x11.
4. fetch_en=0 with count=2 and out_ready=1. Required: exactly 2 more outputs, then out_valid=0; pc unchanged. Set fetch_en=1: fetching resumes from the held pc.
5. Wrap: RESET_PC=2^ADDR_W-1. Required: out_pc = 0xFFFFFFFF then 0x00000000.
6. rst=1 mid-stream while the buffer is full and redirect_valid=1. Required: next cycle out_valid=0 and pc=RESET_PC (not redirect_pc). With FETCH_STATS_EN defined, fetch_count=0 and stall_count=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the default address/instruction widths (`ISIZE, `DSIZE), the default
// reset PC, the fetch buffer depth and the buffer entry layout {pc, instr}.
// Ports: none (package only).
// Optional feature macro used by fetch_stage: FETCH_STATS_EN.

`ifndef ISIZE
`define ISIZE 32
`endif

`ifndef DSIZE
`define DSIZE 32
`endif

package fetch_stage_pkg;

  localparam int unsigned ADDR_W_DEF      = `ISIZE;
  localparam int unsigned INSTR_W_DEF     = `DSIZE;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  // Buffer entry layout at default widths: PC in the upper bits, instruction below.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears storage too)
//   flush      - synchronous clear; priority over push and pop
//   push/wdata - enqueue wdata (ignored when full without a pop)
//   pop        - dequeue head (ignored when empty)
//   count      - number of valid entries, 0..2
//   head       - registered head entry, no path from wdata

module fetch_buf
  import fetch_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  localparam logic [1:0] Full = 2'(FETCH_BUF_DEPTH);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign pop_ok  = pop & (count_q != 2'd0);
  assign push_ok = push & ((count_q != Full) | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory read, buffers {pc, instr} in a 2-entry FIFO and hands the head entry
// to decode over a valid/ready handshake. Redirects flush wrong-path entries.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   fetch_en                  - allow new fetches (0 lets the buffer drain)
//   imem_addr / imem_rdata    - instruction memory read address / data
//   redirect_valid/_pc        - taken branch/jump and its word-address target
//   out_valid/out_ready       - handshake with decode
//   out_instr/out_pc          - head instruction and its PC
//   fetch_count, stall_count  - statistics, only with FETCH_STATS_EN defined
// Optional feature macro: FETCH_STATS_EN.

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam int unsigned EntryW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              push;
  logic              pop;
  logic [1:0]        count;
  logic [EntryW-1:0] head;

  assign imem_addr = pc_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  // Full buffer still accepts a push when the head drains the same cycle.
  assign push      = fetch_en & ~redirect_valid & ((count != 2'd2) | pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buf #(
    .WIDTH (EntryW)
  ) u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_q, imem_rdata}),
    .count (count),
    .head  (head)
  );

  assign out_pc    = head[EntryW-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (push) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A cycle model of the PC and buffer
// pushes expected {pc, instr} entries into a queue; the head is compared
// against the queue front whenever the DUT presents valid output.

module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: RESET_PC = 0
  logic        rst, fetch_en, redirect_valid, out_ready, out_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_pc, out_instr;
  // DUT 1: RESET_PC = all ones, for the wrap check
  logic        rst1, fetch_en1, redirect_valid1, out_ready1, out_valid1;
  logic [31:0] redirect_pc1, imem_addr1, imem_rdata1, out_pc1, out_instr1;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, stall_count, fetch_count1, stall_count1;
`endif

  // Instruction memory model: word at addr holds 0x100 + addr.
  assign imem_rdata  = imem_addr + 32'h100;
  assign imem_rdata1 = imem_addr1 + 32'h100;

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut0 (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFF)) dut1 (
    .clk            (clk),
    .rst            (rst1),
    .fetch_en       (fetch_en1),
    .imem_addr      (imem_addr1),
    .imem_rdata     (imem_rdata1),
    .redirect_valid (redirect_valid1),
    .redirect_pc    (redirect_pc1),
    .out_valid      (out_valid1),
    .out_ready      (out_ready1),
    .out_instr      (out_instr1),
    .out_pc         (out_pc1)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count1),
    .stall_count    (stall_count1)
`endif
  );

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  logic [31:0]  m_pc = 32'h0;
  fetch_entry_t exp_q[$];
  int unsigned  m_fetch = 0;
  int unsigned  m_stall = 0;

  // Advance the model for the inputs now applied, clock once, sample at negedge.
  task automatic step();
    logic do_pop, do_push;
    if (rst) begin
      m_pc = 32'h0;
      exp_q.delete();
      m_fetch = 0;
      m_stall = 0;
    end else begin
      if (exp_q.size() != 0 && !out_ready) m_stall++;
      if (redirect_valid) begin
        m_pc = redirect_pc;
        exp_q.delete();
      end else begin
        do_pop  = (exp_q.size() != 0) && out_ready;
        do_push = fetch_en && ((exp_q.size() < 2) || do_pop);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          exp_q.push_back('{pc: m_pc, instr: m_pc + 32'h100});
          m_pc = m_pc + 32'd1;
          m_fetch++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h77;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_errors++; $display("FAIL reset_out: got pc=%h instr=%h want 0/0", out_pc, out_instr);
    end
    n_checks++;
    if (imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_pc: got %h want 00000000", imem_addr);
    end
    redirect_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instr !== 32'(32'h100 + i)) begin
        n_errors++;
        $display("FAIL stream_%0d: got v=%b pc=%h instr=%h want 1/%h/%h", i, out_valid, out_pc,
                 out_instr, 32'(i), 32'(32'h100 + i));
      end
    end
  endtask

  task automatic test_stall();
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0; fetch_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
        n_errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%h want 1/0", k, out_valid, out_pc);
      end
    end
    n_checks++;
    if (imem_addr !== 32'h2) begin
      n_errors++; $display("FAIL stall_pc: got %h want 00000002", imem_addr);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i)) begin
        n_errors++; $display("FAIL stall_release_%0d: got v=%b pc=%h want 1/%h", i, out_valid,
                             out_pc, 32'(i));
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL redirect_flush: got v=%b pc=%h want 0/00000010", out_valid,
                           imem_addr);
    end
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h110) begin
      n_errors++; $display("FAIL redirect_first: got v=%b pc=%h instr=%h want 1/10/110",
                           out_valid, out_pc, out_instr);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h11 || out_instr !== 32'h111) begin
      n_errors++; $display("FAIL redirect_second: got v=%b pc=%h instr=%h want 1/11/111",
                           out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_fetch_disable();
    out_ready = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h11 || imem_addr !== 32'h13) begin
      n_errors++; $display("FAIL drain_full: got v=%b pc=%h addr=%h want 1/11/13", out_valid,
                           out_pc, imem_addr);
    end
    fetch_en = 1'b0; out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h12) begin
      n_errors++; $display("FAIL drain_second: got v=%b pc=%h want 1/12", out_valid, out_pc);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h13) begin
        n_errors++; $display("FAIL drain_empty_%0d: got v=%b addr=%h want 0/13", k, out_valid,
                             imem_addr);
      end
    end
    fetch_en = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h13 || out_instr !== 32'h113) begin
      n_errors++; $display("FAIL drain_resume: got v=%b pc=%h instr=%h want 1/13/113",
                           out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_wrap();
    rst1 = 1'b0;
    step();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_pc1 !== 32'hFFFF_FFFF || out_instr1 !== 32'h0000_00FF) begin
      n_errors++; $display("FAIL wrap_last: got v=%b pc=%h instr=%h want 1/ffffffff/000000ff",
                           out_valid1, out_pc1, out_instr1);
    end
    step();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_pc1 !== 32'h0 || out_instr1 !== 32'h100) begin
      n_errors++; $display("FAIL wrap_zero: got v=%b pc=%h instr=%h want 1/00000000/00000100",
                           out_valid1, out_pc1, out_instr1);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 32'($urandom_range(0, 255));
      step();
      n_checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_errors++; $display("FAIL b2b_valid_%0d: got %b want %b", c, out_valid,
                             exp_q.size() != 0);
      end else if (exp_q.size() != 0) begin
        n_checks++;
        if (out_pc !== exp_q[0].pc || out_instr !== exp_q[0].instr) begin
          n_errors++; $display("FAIL b2b_head_%0d: got pc=%h instr=%h want %h/%h", c, out_pc,
                               out_instr, exp_q[0].pc, exp_q[0].instr);
        end
      end
      n_checks++;
      if (imem_addr !== m_pc) begin
        n_errors++; $display("FAIL b2b_pc_%0d: got %h want %h", c, imem_addr, m_pc);
      end
    end
    redirect_valid = 1'b0;
`ifdef FETCH_STATS_EN
    n_checks++;
    if (fetch_count !== m_fetch || stall_count !== m_stall) begin
      n_errors++; $display("FAIL stats_count: got f=%0d s=%0d want %0d/%0d", fetch_count,
                           stall_count, m_fetch, m_stall);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    fetch_en = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || exp_q.size() != 2) begin
      n_errors++; $display("FAIL mid_full: got v=%b entries=%0d want 1/2", out_valid,
                           exp_q.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h55; rst = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL mid_reset: got v=%b pc=%h want 0/00000000", out_valid,
                           imem_addr);
    end
`ifdef FETCH_STATS_EN
    n_checks++;
    if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      n_errors++; $display("FAIL mid_stats: got f=%0d s=%0d want 0/0", fetch_count, stall_count);
    end
`endif
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h100) begin
      n_errors++; $display("FAIL mid_restart: got v=%b pc=%h instr=%h want 1/0/100", out_valid,
                           out_pc, out_instr);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    rst1 = 1'b1; fetch_en1 = 1'b1; redirect_valid1 = 1'b0; redirect_pc1 = 32'h0;
    out_ready1 = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fetch_disable();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
